// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//   DATA_BITS          : payload bits per 8N1 frame
//   BAUD_MULT_DEFAULT  : clocks per bit on the board (16 MHz / 1666 ~= 9600 baud)
//   state_t            : receiver FSM states, also exported on the debug port
package uart_rx_pkg;
  localparam int DATA_BITS         = 8;
  localparam int BAUD_MULT_DEFAULT = 1666;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/strobe/status out, FSM state for debug.
//   i_rx_data    : async serial line, idle high
//   o_byte_out   : last good byte, held until the next good byte
//   o_data_valid : 1-cycle pulse when o_byte_out updates
//   o_rx_active  : high while a frame is in progress
//   o_frame_err  : 1-cycle pulse when the stop bit is sampled low
//   dbg_state    : current FSM state
// Handshake: o_data_valid and o_frame_err are single-cycle strobes with no ready;
// the consumer must take o_byte_out before the next frame completes.
interface uart_rx_if;
  logic                  i_rx_data;
  logic [7:0]            o_byte_out;
  logic                  o_data_valid;
  logic                  o_rx_active;
  logic                  o_frame_err;
  uart_rx_pkg::state_t   dbg_state;

  modport slave  (input  i_rx_data,
                  output o_byte_out, o_data_valid, o_rx_active, o_frame_err, dbg_state);
  modport master (output i_rx_data,
                  input  o_byte_out, o_data_valid, o_rx_active, o_frame_err, dbg_state);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin. Resets to 1 so the line
// reads idle and no false start is seen coming out of reset.
//   clk, rst : system clock, async active-high reset
//   d        : raw pin
//   q        : synchronised line
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Start bit is re-checked at mid-bit, each data
// bit and the stop bit are sampled one full bit period later, so every sample
// lands near the centre of its bit.
//   i_uart_clk, i_uart_rst : system clock, async active-high reset
//   rx_if (slave)          : serial line in, byte/strobes/status/debug out
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_MULT = BAUD_MULT_DEFAULT
) (
  input  logic       i_uart_clk,
  input  logic       i_uart_rst,
  uart_rx_if.slave   rx_if
);
  localparam int CW = $clog2(BAUD_MULT);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_MULT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BAUD_MULT - 1);

  logic rx_s;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  uart_rx_sync u_sync (
    .clk (i_uart_clk),
    .rst (i_uart_rst),
    .d   (rx_if.i_rx_data),
    .q   (rx_s)
  );

  // State and datapath registers
  always_ff @(posedge i_uart_clk or posedge i_uart_rst) begin
    if (i_uart_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (cnt_q == HALF_M1) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (cnt_q == BIT_M1 && idx_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (cnt_q == BIT_M1) state_d = rx_s ? ST_IDLE : ST_BREAK;
      // A line held low after a bad stop bit must go high before a new start.
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, shift register and registered output strobes
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_START: cnt_d = (cnt_q == HALF_M1) ? '0 : cnt_q + 1'b1;
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;  // wraps to 0 after bit 7
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    rx_if.o_rx_active  = (state_q != ST_IDLE);
    rx_if.o_byte_out   = byte_q;
    rx_if.o_data_valid = valid_q;
    rx_if.o_frame_err  = err_q;
    rx_if.dbg_state    = state_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a BAUD_MULT=4 instance for the directed/random scenarios and
// a BAUD_MULT=3 instance fed by a transmitter model for the loopback string.
module tb_uart_rx;
  import uart_rx_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if if4 ();
  uart_rx_if if3 ();

  uart_rx #(.BAUD_MULT(4)) dut  (.i_uart_clk(clk), .i_uart_rst(rst), .rx_if(if4));
  uart_rx #(.BAUD_MULT(3)) dut3 (.i_uart_clk(clk), .i_uart_rst(rst), .rx_if(if3));

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected bytes and bytes observed on valid strobes
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got3_q[$];
  int err_cnt  = 0;
  int err3_cnt = 0;
  int wide_cnt = 0;
  int cyc      = 0;
  int last_valid_cyc = 0;
  logic prev_v4 = 1'b0, prev_e4 = 1'b0, prev_v3 = 1'b0, prev_e3 = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: capture strobes, flag any strobe wider than one cycle
  always @(negedge clk) begin
    if (if4.o_data_valid) begin
      got_q.push_back(if4.o_byte_out);
      if (!prev_v4) last_valid_cyc = cyc;
    end
    if (if4.o_frame_err && !prev_e4) err_cnt++;
    if (if3.o_data_valid) got3_q.push_back(if3.o_byte_out);
    if (if3.o_frame_err && !prev_e3) err3_cnt++;
    if ((if4.o_data_valid && prev_v4) || (if4.o_frame_err && prev_e4) ||
        (if3.o_data_valid && prev_v3) || (if3.o_frame_err && prev_e3))
      wide_cnt++;
    prev_v4 = if4.o_data_valid;
    prev_e4 = if4.o_frame_err;
    prev_v3 = if3.o_data_valid;
    prev_e3 = if3.o_frame_err;
  end

  // Drivers: hold a line level for n clocks (called on a negedge)
  task automatic line4(input logic v, input int n);
    if4.i_rx_data = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic line3(input logic v, input int n);
    if3.i_rx_data = v;
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model: start, 8 data LSB first, stop
  task automatic send4(input logic [7:0] b, input logic stop);
    line4(1'b0, 4);
    for (int i = 0; i < 8; i++) line4(b[i], 4);
    line4(stop, 4);
  endtask

  task automatic send3(input logic [7:0] b);
    line3(1'b0, 3);
    for (int i = 0; i < 8; i++) line3(b[i], 3);
    line3(1'b1, 3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (if4.o_byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte: got %h exp 00", if4.o_byte_out); end
    checks++; if (if4.o_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", if4.o_data_valid); end
    checks++; if (if4.o_rx_active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b exp 0", if4.o_rx_active); end
    checks++; if (if4.o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", if4.o_frame_err); end
    checks++; if (if4.dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d exp IDLE", if4.dbg_state); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int start_cyc, lat;
    b = 8'h55;
    got_q.delete();
    err_cnt = 0;
    start_cyc = cyc;
    line4(1'b0, 4);
    for (int i = 0; i < 8; i++) begin
      line4(b[i], 4);
      if (i == 3) begin
        checks++; if (if4.o_rx_active !== 1'b1) begin failures++; $display("FAIL basic_active: got %b exp 1", if4.o_rx_active); end
      end
    end
    line4(1'b1, 4);
    line4(1'b1, 8);
    lat = last_valid_cyc - start_cyc;
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL basic_count: got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h55) begin failures++; $display("FAIL basic_byte: got %h exp 55", got_q[0]); end
    end
    checks++; if (if4.o_byte_out !== 8'h55) begin failures++; $display("FAIL basic_hold: got %h exp 55", if4.o_byte_out); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL basic_err: got %0d exp 0", err_cnt); end
    // 2 sync + 1 detect + HALF(2) + 9*4, +/-1
    checks++; if (lat < 40 || lat > 42) begin failures++; $display("FAIL basic_latency: got %0d exp 41+/-1", lat); end
    checks++; if (if4.o_rx_active !== 1'b0) begin failures++; $display("FAIL basic_idle: got %b exp 0", if4.o_rx_active); end
  endtask

  task automatic test_glitch();
    got_q.delete();
    err_cnt = 0;
    line4(1'b0, 1);
    line4(1'b1, 10);
    checks++; if (if4.dbg_state !== ST_IDLE) begin failures++; $display("FAIL glitch_state: got %0d exp IDLE", if4.dbg_state); end
    checks++; if (got_q.size() != 0 || err_cnt != 0) begin failures++; $display("FAIL glitch_pulse: got valid=%0d err=%0d exp 0/0", got_q.size(), err_cnt); end
    checks++; if (if4.o_byte_out !== 8'h55) begin failures++; $display("FAIL glitch_byte: got %h exp 55", if4.o_byte_out); end
  endtask

  task automatic test_framing();
    got_q.delete();
    err_cnt = 0;
    send4(8'hA3, 1'b0);
    line4(1'b0, 20);
    line4(1'b1, 8);
    checks++; if (err_cnt != 1) begin failures++; $display("FAIL frame_err_count: got %0d exp 1", err_cnt); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL frame_no_valid: got %0d exp 0", got_q.size()); end
    checks++; if (if4.o_byte_out !== 8'h55) begin failures++; $display("FAIL frame_hold: got %h exp 55", if4.o_byte_out); end
    checks++; if (if4.dbg_state !== ST_IDLE) begin failures++; $display("FAIL frame_state: got %0d exp IDLE", if4.dbg_state); end
    send4(8'h3C, 1'b1);
    line4(1'b1, 8);
    checks++; if (got_q.size() != 1 || if4.o_byte_out !== 8'h3C) begin failures++; $display("FAIL frame_recover: got n=%0d byte=%h exp 1/3c", got_q.size(), if4.o_byte_out); end
    checks++; if (err_cnt != 1) begin failures++; $display("FAIL frame_recover_err: got %0d exp 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    pat = '{8'h00, 8'hFF, 8'h81};
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send4(pat[i], 1'b1);
    end
    line4(1'b1, 8);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL b2b_err: got %0d exp 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h7E;
    got_q.delete();
    err_cnt = 0;
    line4(1'b0, 4);
    for (int i = 0; i < 4; i++) line4(b[i], 4);
    rst = 1'b1;
    line4(1'b1, 1);
    checks++; if (if4.o_byte_out !== 8'h00 || if4.o_data_valid !== 1'b0 || if4.o_rx_active !== 1'b0 || if4.o_frame_err !== 1'b0)
      begin failures++; $display("FAIL midrst_outputs: got byte=%h v=%b a=%b e=%b exp all 0", if4.o_byte_out, if4.o_data_valid, if4.o_rx_active, if4.o_frame_err); end
    checks++; if (if4.dbg_state !== ST_IDLE) begin failures++; $display("FAIL midrst_state: got %0d exp IDLE", if4.dbg_state); end
    line4(1'b1, 3);
    rst = 1'b0;
    line4(1'b1, 8);
    send4(8'h12, 1'b1);
    line4(1'b1, 8);
    checks++; if (got_q.size() != 1 || if4.o_byte_out !== 8'h12) begin failures++; $display("FAIL midrst_after: got n=%0d byte=%h exp 1/12", got_q.size(), if4.o_byte_out); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL midrst_err: got %0d exp 0", err_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] b, last_good;
    logic good;
    int gap, exp_err;
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
    exp_err = 0;
    last_good = 8'h12;
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 5);
      send4(b, good);
      if (good) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_err++;
        line4(1'b1, 4);  // line must return high before the next start
      end
      line4(1'b1, gap);
    end
    line4(1'b1, 8);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt != exp_err) begin failures++; $display("FAIL rand_err: got %0d exp %0d", err_cnt, exp_err); end
    checks++; if (if4.o_byte_out !== last_good) begin failures++; $display("FAIL rand_hold: got %h exp %h", if4.o_byte_out, last_good); end
  endtask

  task automatic test_loopback();
    string msg;
    msg = "Hello World!\n";
    got3_q.delete();
    err3_cnt = 0;
    for (int i = 0; i < msg.len(); i++) send3(msg[i]);
    line3(1'b1, 8);
    checks++; if (got3_q.size() != msg.len()) begin failures++; $display("FAIL loop_count: got %0d exp %0d", got3_q.size(), msg.len()); end
    else for (int i = 0; i < msg.len(); i++) begin
      checks++; if (got3_q[i] !== msg[i]) begin failures++; $display("FAIL loop_char%0d: got %h exp %h", i, got3_q[i], msg[i]); end
    end
    checks++; if (err3_cnt != 0) begin failures++; $display("FAIL loop_err: got %0d exp 0", err3_cnt); end
  endtask

  initial begin
    if4.i_rx_data = 1'b1;
    if3.i_rx_data = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_loopback();
    checks++; if (wide_cnt != 0) begin failures++; $display("FAIL pulse_width: got %0d wide strobes exp 0", wide_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
